// File: rtl/lsu_wb_bridge_pkg.sv
// Shared definitions for the RV32I load/store unit: FSM state encodings,
// funct3 width/sign codes and byte-lane size masks.
package lsu_wb_bridge_pkg;

    typedef enum logic [2:0] {
        LSU_ST_IDLE  = 3'd0,
        LSU_ST_WAIT1 = 3'd1,
        LSU_ST_REQ2  = 3'd2,
        LSU_ST_WAIT2 = 3'd3,
        LSU_ST_DONE  = 3'd4,
        LSU_ST_FAULT = 3'd5
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_mask = MASK_B;
            2'b01:   size_mask = MASK_H;
            default: size_mask = MASK_W;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 3'd1;
            2'b01:   size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: picks the addressed bytes out of a
// (possibly two-word) window and applies sign or zero extension.
module lsu_load_align
    import lsu_wb_bridge_pkg::*;
(
    input  logic [31:0] word_lo_i,
    input  logic [31:0] word_hi_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    logic [31:0] lane;

    assign lane = 32'({word_hi_i, word_lo_i} >> {off_i, 3'b000});

    always_comb begin
        case (funct3_i)
            F3_B:    rdata_o = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rdata_o = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   rdata_o = {24'b0, lane[7:0]};
            F3_HU:   rdata_o = {16'b0, lane[15:0]};
            default: rdata_o = lane;
        endcase
    end

endmodule

// File: rtl/lsu_wb_bridge.sv
// RV32I load/store unit feeding a native-to-wishbone master. Define
// MISALIGN_SPLIT_EN to execute misaligned accesses (split when spanning).
module lsu_wb_bridge
    import lsu_wb_bridge_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_ld,
    input  logic        i_st,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_en,
    output logic        o_we,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic [3:0]  o_strobe,
    input  logic        i_valid,
    input  logic [31:0] i_data
);

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_e  state_q, state_d;
    logic        en_q, en_d, we_q, we_d, split_q, split_d, ld_q, ld_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, hi_data_q, hi_data_d;
    logic [3:0]  strobe_q, strobe_d, hi_strobe_q, hi_strobe_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] word1_q, word1_d, rdata_q, rdata_d;

    logic        req, ld_legal, st_legal, illegal, misaligned, spanning, accept;
    logic [1:0]  off;
    logic [7:0]  strobe8;
    logic [63:0] lane64;
    logic [31:0] align_lo, align_hi, align_out;

    // Request decode: legality, alignment and whether the access crosses a word.
    assign req        = i_ld | i_st;
    assign off        = i_addr[1:0];
    assign strobe8    = {4'b0, size_mask(i_funct3)} << off;
    assign lane64     = {32'b0, i_wdata} << {off, 3'b000};
    assign ld_legal   = (i_funct3 == F3_B) | (i_funct3 == F3_H) | (i_funct3 == F3_W)
                      | (i_funct3 == F3_BU) | (i_funct3 == F3_HU);
    assign st_legal   = (i_funct3 == F3_B) | (i_funct3 == F3_H) | (i_funct3 == F3_W);
    assign illegal    = (i_ld & i_st) | (i_ld & ~ld_legal) | (i_st & ~st_legal);
    assign misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0])
                      | ((i_funct3[1:0] == 2'b10) & (off != 2'b00));
    assign spanning   = ({1'b0, off} + size_bytes(i_funct3)) > 3'd4;
    assign accept     = req & ~illegal & (~misaligned | SPLIT_EN);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= LSU_ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_ST_IDLE:  if (req) state_d = accept ? LSU_ST_WAIT1 : LSU_ST_FAULT;
            LSU_ST_WAIT1: if (i_valid) state_d = split_q ? LSU_ST_REQ2 : LSU_ST_DONE;
            LSU_ST_REQ2:  state_d = LSU_ST_WAIT2;
            LSU_ST_WAIT2: if (i_valid) state_d = LSU_ST_DONE;
            default:      state_d = LSU_ST_IDLE;
        endcase
    end

    // After a split, the first captured word is the low half of the window.
    assign align_lo = (state_q == LSU_ST_WAIT2) ? word1_q : i_data;
    assign align_hi = (state_q == LSU_ST_WAIT2) ? i_data : 32'b0;

    lsu_load_align u_align (
        .word_lo_i (align_lo),
        .word_hi_i (align_hi),
        .off_i     (off_q),
        .funct3_i  (funct3_q),
        .rdata_o   (align_out)
    );

    always_comb begin
        en_d        = 1'b0;
        we_d        = we_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strobe_d    = strobe_q;
        hi_data_d   = hi_data_q;
        hi_strobe_d = hi_strobe_q;
        split_d     = split_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        ld_d        = ld_q;
        word1_d     = word1_q;
        rdata_d     = rdata_q;
        case (state_q)
            LSU_ST_IDLE: if (accept) begin
                en_d        = 1'b1;
                we_d        = i_st;
                addr_d      = {i_addr[31:2], 2'b00};
                data_d      = lane64[31:0];
                strobe_d    = strobe8[3:0];
                hi_data_d   = lane64[63:32];
                hi_strobe_d = strobe8[7:4];
                split_d     = spanning & SPLIT_EN;
                off_d       = off;
                funct3_d    = i_funct3;
                ld_d        = i_ld;
            end
            LSU_ST_WAIT1: if (i_valid) begin
                word1_d = i_data;
                if (!split_q && ld_q) rdata_d = align_out;
            end
            LSU_ST_REQ2: begin
                en_d     = 1'b1;
                addr_d   = addr_q + 32'd4;
                data_d   = hi_data_q;
                strobe_d = hi_strobe_q;
            end
            LSU_ST_WAIT2: if (i_valid && ld_q) rdata_d = align_out;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'b0;
            data_q      <= 32'b0;
            strobe_q    <= 4'b0;
            hi_data_q   <= 32'b0;
            hi_strobe_q <= 4'b0;
            split_q     <= 1'b0;
            off_q       <= 2'b0;
            funct3_q    <= 3'b0;
            ld_q        <= 1'b0;
            word1_q     <= 32'b0;
            rdata_q     <= 32'b0;
        end else begin
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            hi_data_q   <= hi_data_d;
            hi_strobe_q <= hi_strobe_d;
            split_q     <= split_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            ld_q        <= ld_d;
            word1_q     <= word1_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_stall  = ((state_q != LSU_ST_IDLE) && (state_q != LSU_ST_DONE) && (state_q != LSU_ST_FAULT))
                    || ((state_q == LSU_ST_IDLE) && req);
    assign o_done   = (state_q == LSU_ST_DONE);
    assign o_fault  = (state_q == LSU_ST_FAULT);
    assign o_rdata  = rdata_q;
    assign o_en     = en_q;
    assign o_we     = we_q;
    assign o_addr   = addr_q;
    assign o_data   = data_q;
    assign o_strobe = strobe_q;

endmodule
